uart_rx: RTL and testbench

UART receiver that deserialises the TX_OUT line of a matching transmitter back into parallel bytes. It sits on the receive side of the UART link in the register-file/ALU system, between the RX pin and the RX-side data synchroniser. It oversamples RX_IN by a runtime prescale, majority-votes each bit and checks start, optional parity and stop. Each good frame produces a one-cycle data_valid pulse with P_DATA.

---
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversamples a serial line by a runtime prescale, majority-votes
// three mid-bit samples, checks start/parity/stop and emits one-cycle result pulses.
module uart_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                  r_state;
   state_t                  w_next;

   logic                    r_sync1;
   logic                    r_sync2;
   logic [5:0]              r_edge_cnt;
   logic [BIT_CNT_W-1:0]    r_bit_cnt;
   logic [5:0]              r_prescale;
   logic                    r_par_en;
   logic                    r_par_typ;
   logic [2:0]              r_samp;
   logic [DATA_WIDTH-1:0]   r_shift;
   logic                    r_par_flag;
   logic [DATA_WIDTH-1:0]   r_p_data;
   logic                    r_data_valid;
   logic                    r_par_err;
   logic                    r_stp_err;

   logic                    w_rx_s;
   logic [5:0]              w_half;
   logic                    w_samp0_pt;
   logic                    w_samp1_pt;
   logic                    w_samp2_pt;
   logic                    w_vote_pt;
   logic                    w_bit_end;
   logic                    w_last_bit;
   logic                    w_vote;
   logic                    w_exp_par;
   logic                    w_frame_done;
   logic                    w_good;
   logic                    w_set_par_err;
   logic                    w_set_stp_err;

   assign w_rx_s     = r_sync2;
   assign w_half     = r_prescale >> 1;
   assign w_samp0_pt = (r_edge_cnt == w_half - 6'd1);
   assign w_samp1_pt = (r_edge_cnt == w_half);
   assign w_samp2_pt = (r_edge_cnt == w_half + 6'd1);
   assign w_vote_pt  = (r_edge_cnt == w_half + 6'd2);
   // Modulo-64 compare: an illegal prescale (even 0) still ends each bit within 64 cycles.
   assign w_bit_end  = (r_edge_cnt == r_prescale - 6'd1);
   assign w_last_bit = (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
   assign w_vote     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
   assign w_exp_par  = (^r_shift) ^ r_par_typ;

   // Two-flop synchroniser for the asynchronous serial line.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         // NOTE: synchroniser resets to the idle-high line level so reset release cannot fake a start bit.
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments keep the two flops a true two-stage pipeline.
         r_sync1 <= RX_IN;
         r_sync2 <= r_sync1;
      end
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns w_next and no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (!w_rx_s) w_next = S_START;
         S_START: begin
            if (w_vote_pt && w_vote) w_next = S_IDLE;
            else if (w_bit_end)      w_next = S_DATA;
         end
         S_DATA:   if (w_bit_end && w_last_bit) w_next = r_par_en ? S_PARITY : S_STOP;
         S_PARITY: if (w_bit_end) w_next = S_STOP;
         S_STOP:   if (w_bit_end) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Frame-evaluation decode, registered into the result pulses below.
   always_comb begin
      w_frame_done  = (r_state == S_STOP) && w_bit_end;
      w_good        = w_frame_done && w_vote && !r_par_flag;
      w_set_par_err = w_frame_done && r_par_flag;
      w_set_stp_err = w_frame_done && !w_vote;
   end

   // Oversampling counters: edge_cnt within a bit, bit_cnt across data bits.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
      end else begin
         if (r_state == S_IDLE || w_bit_end) r_edge_cnt <= '0;
         else                                r_edge_cnt <= r_edge_cnt + 6'd1;
         if (r_state != S_DATA) r_bit_cnt <= '0;
         else if (w_bit_end)    r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   end

   // Frame configuration is captured at start detection and held for the frame.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_prescale <= '0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
      end else if (r_state == S_IDLE && !w_rx_s) begin
         r_prescale <= prescale;
         r_par_en   <= PAR_EN;
         r_par_typ  <= PAR_TYP;
      end
   end

   // Three mid-bit samples, payload shift register and parity flag.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_samp     <= 3'b111;
         r_shift    <= '0;
         r_par_flag <= 1'b0;
      end else begin
         if (w_samp0_pt) r_samp[0] <= w_rx_s;
         if (w_samp1_pt) r_samp[1] <= w_rx_s;
         if (w_samp2_pt) r_samp[2] <= w_rx_s;
         if (r_state == S_DATA && w_bit_end)
            r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
         if (r_state == S_IDLE)
            r_par_flag <= 1'b0;
         else if (r_state == S_PARITY && w_bit_end)
            r_par_flag <= (w_vote != w_exp_par);
      end
   end

   // Registered result: payload update with data_valid, or error pulses.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_p_data     <= '0;
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
      end else begin
         r_data_valid <= w_good;
         r_par_err    <= w_set_par_err;
         r_stp_err    <= w_set_stp_err;
         if (w_good) r_p_data <= r_shift;
      end
   end

   assign P_DATA     = r_p_data;
   assign data_valid = r_data_valid;
   assign par_err    = r_par_err;
   assign stp_err    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives hand-built frames and compares result pulses,
// payloads and latencies against hand-computed values.
module tb_uart_rx;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic [5:0] prescale = 6'd8;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .prescale   (prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   always #5 CLK = ~CLK;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Cycle counter and pulse monitor (sampled on the falling edge).
   int         cyc = 0;
   int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
   int         se_cyc = 0;
   int         width_err = 0;
   int         dv_at [0:63];
   logic [7:0] dv_data [0:63];
   logic       prev_dv = 1'b0, prev_pe = 1'b0, prev_se = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (!RST) begin
         prev_dv <= 1'b0;
         prev_pe <= 1'b0;
         prev_se <= 1'b0;
      end else begin
         if (data_valid) begin
            if (dv_cnt < 64) begin
               dv_data[dv_cnt] <= P_DATA;
               dv_at[dv_cnt]   <= cyc;
            end
            dv_cnt <= dv_cnt + 1;
         end
         if (par_err) pe_cnt <= pe_cnt + 1;
         if (stp_err) begin
            se_cnt <= se_cnt + 1;
            se_cyc <= cyc;
         end
         if ((data_valid && prev_dv) || (par_err && prev_pe) || (stp_err && prev_se))
            width_err <= width_err + 1;
         prev_dv <= data_valid;
         prev_pe <= par_err;
         prev_se <= stp_err;
      end
   end

   int fall_cyc = 0;
   int dv0 = 0, pe0 = 0, se0 = 0;

   task automatic snap();
      dv0 = dv_cnt;
      pe0 = pe_cnt;
      se0 = se_cnt;
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   // Drive one frame starting at a falling clock edge. glitch_bit inverts the
   // middle vote sample of that frame bit; rst_bit asserts reset mid-way through
   // that frame bit and abandons the frame (line returns to idle).
   task automatic send_frame(input logic [7:0] data, input int p, input bit par_en,
                             input bit par_bit, input bit stop_bit,
                             input int glitch_bit, input int rst_bit);
      logic bits [0:10];
      int   nb;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = data[i];
      bits[9]  = par_en ? par_bit : stop_bit;
      bits[10] = stop_bit;
      nb = par_en ? 11 : 10;
      fall_cyc = cyc;
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < p; k++) begin
            if (b == rst_bit && k == p / 2) begin
               RST   = 1'b0;
               RX_IN = 1'b1;
               return;
            end
            RX_IN = (b == glitch_bit && k == p / 2 + 1) ? ~bits[b] : bits[b];
            @(negedge CLK);
         end
      end
      RX_IN = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f1;
      // Reset values
      repeat (3) @(negedge CLK);
      check("rst_p_data", P_DATA, 8'h00);
      check("rst_dv", data_valid, 1'b0);
      check("rst_pe", par_err, 1'b0);
      check("rst_se", stp_err, 1'b0);
      RST = 1'b1;
      idle(5);

      // Good frame, even parity, P=8
      prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
      snap();
      send_frame(8'hA5, 8, 1, 1'b0, 1'b1, -1, -1);
      idle(10);
      check("a5_dv_cnt", dv_cnt - dv0, 1);
      check("a5_latency", dv_at[dv0] - fall_cyc, 91);
      check("a5_data", P_DATA, 8'hA5);
      check("a5_pe", pe_cnt - pe0, 0);
      check("a5_se", se_cnt - se0, 0);

      // False start at P=16, then a good 0x3C frame
      prescale = 6'd16;
      snap();
      RX_IN = 1'b0;
      repeat (3) @(negedge CLK);
      idle(60);
      check("fs_dv", dv_cnt - dv0, 0);
      check("fs_pe", pe_cnt - pe0, 0);
      check("fs_se", se_cnt - se0, 0);
      snap();
      send_frame(8'h3C, 16, 1, 1'b0, 1'b1, -1, -1);
      idle(10);
      check("3c_dv_cnt", dv_cnt - dv0, 1);
      check("3c_latency", dv_at[dv0] - fall_cyc, 179);
      check("3c_data", P_DATA, 8'h3C);

      // Good odd-parity frame so a later hold of P_DATA is observable
      PAR_TYP = 1'b1;
      snap();
      send_frame(8'h96, 16, 1, 1'b1, 1'b1, -1, -1);
      idle(10);
      check("96_dv_cnt", dv_cnt - dv0, 1);
      check("96_data", P_DATA, 8'h96);
      check("96_pe", pe_cnt - pe0, 0);

      // Parity error: odd parity expects 1 for 0x3C, send 0
      snap();
      send_frame(8'h3C, 16, 1, 1'b0, 1'b1, -1, -1);
      idle(10);
      check("perr_pe", pe_cnt - pe0, 1);
      check("perr_se", se_cnt - se0, 0);
      check("perr_dv", dv_cnt - dv0, 0);
      check("perr_hold", P_DATA, 8'h96);

      // Stop error at P=32, no parity
      prescale = 6'd32; PAR_EN = 1'b0;
      snap();
      send_frame(8'h81, 32, 0, 1'b0, 1'b0, -1, -1);
      idle(10);
      check("serr_se", se_cnt - se0, 1);
      check("serr_latency", se_cyc - fall_cyc, 323);
      check("serr_pe", pe_cnt - pe0, 0);
      check("serr_dv", dv_cnt - dv0, 0);
      check("serr_hold", P_DATA, 8'h96);

      // Same byte with a one-cycle glitch on the middle sample of data bit 3
      snap();
      send_frame(8'h81, 32, 0, 1'b0, 1'b1, 4, -1);
      idle(10);
      check("glitch_dv", dv_cnt - dv0, 1);
      check("glitch_data", P_DATA, 8'h81);
      check("glitch_se", se_cnt - se0, 0);

      // Back-to-back frames at P=8, then reset during data bit 4 of a fourth frame
      prescale = 6'd8; PAR_EN = 1'b0;
      idle(20);
      snap();
      send_frame(8'h00, 8, 0, 1'b0, 1'b1, -1, -1);
      f1 = fall_cyc;
      send_frame(8'hFF, 8, 0, 1'b0, 1'b1, -1, -1);
      send_frame(8'h5A, 8, 0, 1'b0, 1'b1, -1, -1);
      send_frame(8'h33, 8, 0, 1'b0, 1'b1, -1, 5);
      #1;
      check("mrst_p_data", P_DATA, 8'h00);
      check("mrst_dv", data_valid, 1'b0);
      check("mrst_pe", par_err, 1'b0);
      check("mrst_se", stp_err, 1'b0);
      check("b2b_cnt", dv_cnt - dv0, 3);
      check("b2b_latency", dv_at[dv0] - f1, 83);
      check("b2b_data0", dv_data[dv0], 8'h00);
      check("b2b_data1", dv_data[dv0+1], 8'hFF);
      check("b2b_data2", dv_data[dv0+2], 8'h5A);
      check("b2b_errs", (pe_cnt - pe0) + (se_cnt - se0), 0);
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      snap();
      idle(120);
      check("post_rst_dv", dv_cnt - dv0, 0);
      check("post_rst_err", (pe_cnt - pe0) + (se_cnt - se0), 0);
      check("post_rst_data", P_DATA, 8'h00);
      snap();
      send_frame(8'h12, 8, 0, 1'b0, 1'b1, -1, -1);
      idle(10);
      check("12_dv_cnt", dv_cnt - dv0, 1);
      check("12_data", P_DATA, 8'h12);

      // Break condition: line held low gives a stop error per frame
      snap();
      RX_IN = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         #1;
         if (se_cnt != se0) break;
      end
      RX_IN = 1'b1;
      idle(60);
      check("brk_se", se_cnt - se0, 1);
      check("brk_dv", dv_cnt - dv0, 0);
      check("brk_hold", P_DATA, 8'h12);

      check("pulse_width", width_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
